// File: rtl/qnigma_mac_pkg.sv
// Shared constants and types for the receive-side MAC header parser.
package qnigma_mac_pkg;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int         HDR_LEN  = 14;

    typedef logic [47:0] mac_addr_t;

    localparam mac_addr_t BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        mac_addr_t   dst;
        mac_addr_t   src;
        logic [15:0] ethertype;
    } mac_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PLD,
        ST_DROP
    } state_t;

    function automatic logic addr_hit(input mac_addr_t dst,
                                      input mac_addr_t own);
        return (dst == own) || (dst == BCAST_ADDR);
    endfunction

endpackage

// File: rtl/qnigma_mac_rx_parse_if.sv
// Framed byte stream carrying forwarded payload to upper layers.
interface qnigma_mac_rx_parse_if;

    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;

    modport master (output dat, val, sof, eof, err);
    modport slave  (input  dat, val, sof, eof, err);

endinterface

// File: rtl/qnigma_sipo_mac.sv
// Header window: index 0 is the byte presented this cycle,
// higher indices are progressively older shifted-in bytes.
module qnigma_sipo_mac #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic [WIDTH-1:0]              din_i,
    output logic [LENGTH-1:0][WIDTH-1:0]  win_o
);

    logic [LENGTH-1:1][WIDTH-1:0] hist_q;
    logic [LENGTH-1:1][WIDTH-1:0] hist_d;

    assign win_o = {hist_q, din_i};

    always_comb begin
        hist_d = hist_q;
        if (en_i) begin
            hist_d = win_o[LENGTH-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/qnigma_mac_rx_parse.sv
// Receive MAC parser: strips preamble/SFD, filters on destination
// address and forwards payload+FCS as a framed byte stream.
module qnigma_mac_rx_parse
    import qnigma_mac_pkg::*;
#(
    parameter int MAX_PLD = 1504,
    parameter int PRE_MAX = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_dat_i,
    input  logic                         rx_val_i,
    input  logic                         rx_err_i,
    input  mac_addr_t                    mac_addr_i,
    output logic                         hdr_val_o,
    output mac_addr_t                    dst_o,
    output mac_addr_t                    src_o,
    output logic [15:0]                  ethertype_o,
    qnigma_mac_rx_parse_if.master        pld,
    output logic                         frame_err_o
);

    localparam int CNT_W = $clog2(MAX_PLD + PRE_MAX + HDR_LEN + 1);

    state_t               state_q, state_d;
    logic                 val_prev_q, val_prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           hold_q, hold_d;
    logic                 err_q, err_d;
    mac_hdr_t             hdr_q, hdr_d;
    logic                 hdr_val_q, hdr_val_d;
    logic                 ferr_q, ferr_d;
    logic [7:0]           odat_q, odat_d;
    logic                 oval_q, oval_d;
    logic                 osof_q, osof_d;
    logic                 oeof_q, oeof_d;
    logic                 oerr_q, oerr_d;

    logic [HDR_LEN-1:0][7:0] win;
    mac_hdr_t                hdr_now;
    logic                    rise;
    logic                    win_en;

    assign rise    = rx_val_i & ~val_prev_q;
    assign win_en  = (state_q == ST_HDR) & rx_val_i;
    assign hdr_now = win;

    qnigma_sipo_mac #(
        .WIDTH  (8),
        .LENGTH (HDR_LEN)
    ) u_win (
        .clk    (clk),
        .rst    (rst),
        .en_i   (win_en),
        .din_i  (rx_dat_i),
        .win_o  (win)
    );

    always_comb begin
        state_d    = state_q;
        val_prev_d = rx_val_i;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        err_d      = err_q;
        hdr_d      = hdr_q;
        hdr_val_d  = 1'b0;
        ferr_d     = 1'b0;
        odat_d     = odat_q;
        oval_d     = 1'b0;
        osof_d     = 1'b0;
        oeof_d     = 1'b0;
        oerr_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                // Only a fresh val edge starts a frame; mid-frame data is ignored.
                if (rise) begin
                    if (rx_dat_i == PRE_BYTE && !rx_err_i) begin
                        state_d = ST_PRE;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_DROP;
                        ferr_d  = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!rx_val_i) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else if (rx_err_i) begin
                    state_d = ST_DROP;
                    ferr_d  = 1'b1;
                end else if (rx_dat_i == PRE_BYTE) begin
                    if (cnt_q == CNT_W'(PRE_MAX)) begin
                        state_d = ST_DROP;
                        ferr_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (rx_dat_i == SFD_BYTE) begin
                    state_d = ST_HDR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DROP;
                    ferr_d  = 1'b1;
                end
            end
            ST_HDR: begin
                if (!rx_val_i) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else if (rx_err_i) begin
                    state_d = ST_DROP;
                    ferr_d  = 1'b1;
                end else if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                    // Address miss is a normal filter outcome, not an error.
                    if (addr_hit(hdr_now.dst, mac_addr_i)) begin
                        hdr_d     = hdr_now;
                        hdr_val_d = 1'b1;
                        state_d   = ST_PLD;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PLD: begin
                if (!rx_val_i) begin
                    state_d = ST_IDLE;
                    if (cnt_q == '0) begin
                        ferr_d = 1'b1;
                    end else begin
                        oval_d = 1'b1;
                        odat_d = hold_q;
                        osof_d = (cnt_q == CNT_W'(1));
                        oeof_d = 1'b1;
                        oerr_d = err_q;
                    end
                end else begin
                    err_d = err_q | rx_err_i;
                    if (cnt_q != '0) begin
                        oval_d = 1'b1;
                        odat_d = hold_q;
                        osof_d = (cnt_q == CNT_W'(1));
                    end
                    // A byte beyond the limit closes the frame as truncated.
                    if (cnt_q == CNT_W'(MAX_PLD)) begin
                        oeof_d  = 1'b1;
                        oerr_d  = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        hold_d = rx_dat_i;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!rx_val_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            val_prev_q <= 1'b1;
            cnt_q      <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
            hdr_q      <= '0;
            hdr_val_q  <= 1'b0;
            ferr_q     <= 1'b0;
            odat_q     <= '0;
            oval_q     <= 1'b0;
            osof_q     <= 1'b0;
            oeof_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_prev_q <= val_prev_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            hdr_q      <= hdr_d;
            hdr_val_q  <= hdr_val_d;
            ferr_q     <= ferr_d;
            odat_q     <= odat_d;
            oval_q     <= oval_d;
            osof_q     <= osof_d;
            oeof_q     <= oeof_d;
            oerr_q     <= oerr_d;
        end
    end

    assign hdr_val_o   = hdr_val_q;
    assign dst_o       = hdr_q.dst;
    assign src_o       = hdr_q.src;
    assign ethertype_o = hdr_q.ethertype;
    assign frame_err_o = ferr_q;

    assign pld.dat = odat_q;
    assign pld.val = oval_q;
    assign pld.sof = osof_q;
    assign pld.eof = oeof_q;
    assign pld.err = oerr_q;

endmodule

// File: tb/tb_qnigma_mac_rx_parse.sv
// Scoreboard bench for the receive MAC parser; a second instance
// runs with a short payload limit to exercise truncation.
module tb_qnigma_mac_rx_parse;
    import qnigma_mac_pkg::*;

    localparam mac_addr_t MAC  = 48'h0200_0000_0001;
    localparam mac_addr_t SRC  = 48'h0200_0000_0002;
    localparam mac_addr_t MISS = 48'h0200_0000_0009;
    localparam int        MAX2 = 8;

    typedef struct {
        logic [7:0] dat;
        logic       sof;
        logic       eof;
        logic       err;
        int         cyc;
    } pexp_t;

    typedef struct {
        mac_hdr_t h;
        int       cyc;
    } hexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_val = 1'b0;
    logic       rx_err = 1'b0;

    logic        hdr_val1, hdr_val2, ferr1, ferr2;
    mac_addr_t   dst1, src1, dst2, src2;
    logic [15:0] et1, et2;

    qnigma_mac_rx_parse_if pld1();
    qnigma_mac_rx_parse_if pld2();

    qnigma_mac_rx_parse dut1 (
        .clk (clk), .rst (rst),
        .rx_dat_i (rx_dat), .rx_val_i (rx_val), .rx_err_i (rx_err),
        .mac_addr_i (MAC),
        .hdr_val_o (hdr_val1), .dst_o (dst1), .src_o (src1),
        .ethertype_o (et1), .pld (pld1), .frame_err_o (ferr1)
    );

    qnigma_mac_rx_parse #(.MAX_PLD(MAX2)) dut2 (
        .clk (clk), .rst (rst),
        .rx_dat_i (rx_dat), .rx_val_i (rx_val), .rx_err_i (rx_err),
        .mac_addr_i (MAC),
        .hdr_val_o (hdr_val2), .dst_o (dst2), .src_o (src2),
        .ethertype_o (et2), .pld (pld2), .frame_err_o (ferr2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pexp_t    q1[$];
    pexp_t    q2[$];
    hexp_t    hq[$];
    pexp_t    e1, e2;
    hexp_t    eh;
    mac_hdr_t hlast = '0;
    int checks = 0, errors = 0;
    bit mon_en = 1'b1;
    int pop1 = 0, pop2 = 0, hdr_cnt = 0;
    int ferr1_cnt = 0, ferr2_cnt = 0, ferr1_cyc = -1;

    always @(negedge clk) begin
        if (mon_en && pld1.val) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pld1_extra got dat=%h at cyc %0d, required none",
                         pld1.dat, cyc);
            end else begin
                e1 = q1.pop_front();
                pop1++;
                if ({pld1.dat, pld1.sof, pld1.eof, pld1.err} !==
                    {e1.dat, e1.sof, e1.eof, e1.err} || cyc != e1.cyc) begin
                    errors++;
                    $display("FAIL pld1_byte got %h sof%b eof%b err%b @%0d required %h sof%b eof%b err%b @%0d",
                             pld1.dat, pld1.sof, pld1.eof, pld1.err, cyc,
                             e1.dat, e1.sof, e1.eof, e1.err, e1.cyc);
                end
            end
        end
        if (mon_en && pld2.val) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL pld2_extra got dat=%h at cyc %0d, required none",
                         pld2.dat, cyc);
            end else begin
                e2 = q2.pop_front();
                pop2++;
                if ({pld2.dat, pld2.sof, pld2.eof, pld2.err} !==
                    {e2.dat, e2.sof, e2.eof, e2.err} || cyc != e2.cyc) begin
                    errors++;
                    $display("FAIL pld2_byte got %h sof%b eof%b err%b @%0d required %h sof%b eof%b err%b @%0d",
                             pld2.dat, pld2.sof, pld2.eof, pld2.err, cyc,
                             e2.dat, e2.sof, e2.eof, e2.err, e2.cyc);
                end
            end
        end
        if (mon_en && hdr_val1) begin
            checks++;
            hdr_cnt++;
            if (hq.size() == 0) begin
                errors++;
                $display("FAIL hdr_extra got dst=%h at cyc %0d, required none",
                         dst1, cyc);
            end else begin
                eh = hq.pop_front();
                if ({dst1, src1, et1} !== eh.h || cyc != eh.cyc) begin
                    errors++;
                    $display("FAIL hdr_fields got %h/%h/%h @%0d required %h/%h/%h @%0d",
                             dst1, src1, et1, cyc,
                             eh.h.dst, eh.h.src, eh.h.ethertype, eh.cyc);
                end
            end
        end
        if (mon_en && hdr_val2) begin
            checks++;
            if ({dst2, src2, et2} !== hlast) begin
                errors++;
                $display("FAIL hdr2_fields got %h/%h/%h required %h/%h/%h",
                         dst2, src2, et2, hlast.dst, hlast.src, hlast.ethertype);
            end
        end
        if (ferr1) begin
            ferr1_cnt++;
            ferr1_cyc = cyc;
        end
        if (ferr2) ferr2_cnt++;
    end

    task automatic drive(input logic [7:0] d, input logic e);
        @(posedge clk);
        #1;
        rx_val = 1'b1;
        rx_dat = d;
        rx_err = e;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_val = 1'b0;
            rx_err = 1'b0;
            rx_dat = 8'h00;
        end
    endtask

    task automatic send_frame(input int npre, input mac_addr_t dst,
                              input logic [15:0] et, input int nbytes,
                              input int err_at, input logic [7:0] base);
        mac_hdr_t     h;
        logic [111:0] hv;
        bit           acc, e_any, tr2;
        int           n2;
        h     = '{dst: dst, src: SRC, ethertype: et};
        hv    = h;
        acc   = (dst == MAC || dst == BCAST_ADDR) && npre >= 1 && npre <= 7;
        n2    = (nbytes < MAX2) ? nbytes : MAX2;
        tr2   = nbytes > MAX2;
        e_any = err_at >= 0 && err_at < nbytes;
        repeat (npre) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 14; i++) begin
            drive(hv[111-8*i -: 8], 1'b0);
            if (i == 13 && acc) begin
                hq.push_back('{h, cyc + 1});
                hlast = h;
            end
        end
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = 8'(base + i * 37);
            drive(b, i == err_at);
            if (acc) begin
                q1.push_back('{b, i == 0, i == nbytes - 1,
                               (i == nbytes - 1) && e_any, cyc + 2});
                if (i < n2)
                    q2.push_back('{b, i == 0, i == n2 - 1,
                                   (i == n2 - 1) && (tr2 || e_any), cyc + 2});
            end
        end
        gap(1);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hdr_val1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hdr_val got %b required 0", hdr_val1);
        end
        checks++;
        if ({dst1, src1, et1} !== 112'd0) begin
            errors++;
            $display("FAIL reset_fields got %h/%h/%h required 0", dst1, src1, et1);
        end
        checks++;
        if ({pld1.val, pld1.dat, pld1.sof, pld1.eof, pld1.err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_pld got val%b dat%h required 0", pld1.val, pld1.dat);
        end
        checks++;
        if (ferr1 !== 1'b0 || ferr2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err got %b%b required 00", ferr1, ferr2);
        end
        checks++;
        if ({pld2.val, hdr_val2, dst2} !== 50'd0) begin
            errors++;
            $display("FAIL reset_dut2 got val%b hdr%b dst%h required 0",
                     pld2.val, hdr_val2, dst2);
        end
    endtask

    task automatic test_unicast;
        int h0, p0, f0;
        h0 = hdr_cnt; p0 = pop1; f0 = ferr1_cnt;
        send_frame(7, MAC, 16'h0800, 50, -1, 8'h10);
        gap(4);
        checks++;
        if (q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL uni_drain got %0d pending required 0",
                     q1.size() + q2.size() + hq.size());
        end
        checks++;
        if (hdr_cnt - h0 != 1 || pop1 - p0 != 50) begin
            errors++;
            $display("FAIL uni_counts got hdr %0d bytes %0d required 1 50",
                     hdr_cnt - h0, pop1 - p0);
        end
        checks++;
        if (ferr1_cnt != f0) begin
            errors++;
            $display("FAIL uni_ferr got %0d required 0", ferr1_cnt - f0);
        end
    endtask

    task automatic test_bcast_miss;
        int h0, f0;
        h0 = hdr_cnt; f0 = ferr1_cnt;
        send_frame(7, BCAST_ADDR, 16'h0806, 46, -1, 8'h33);
        send_frame(7, MISS, 16'h0800, 46, -1, 8'h44);
        gap(4);
        checks++;
        if (hdr_cnt - h0 != 1 || q1.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL bcast_miss_hdr got %0d hdrs %0d pending required 1 0",
                     hdr_cnt - h0, q1.size() + hq.size());
        end
        checks++;
        if (ferr1_cnt != f0) begin
            errors++;
            $display("FAIL miss_no_ferr got %0d required 0", ferr1_cnt - f0);
        end
    endtask

    task automatic test_bad_preamble;
        int f0, f20, h0, k;
        f0 = ferr1_cnt; f20 = ferr2_cnt;
        drive(8'h55, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'hAA, 1'b0);
        k = cyc;
        drive(8'h11, 1'b0);
        drive(8'h22, 1'b0);
        gap(2);
        checks++;
        if (ferr1_cnt - f0 != 1 || ferr1_cyc != k + 1 || ferr2_cnt - f20 != 1) begin
            errors++;
            $display("FAIL pre_bad got %0d @%0d required 1 @%0d",
                     ferr1_cnt - f0, ferr1_cyc, k + 1);
        end
        f0 = ferr1_cnt;
        h0 = hdr_cnt;
        send_frame(8, MAC, 16'h0800, 20, -1, 8'h55);
        send_frame(7, MAC, 16'h86DD, 20, -1, 8'h66);
        gap(4);
        checks++;
        if (ferr1_cnt - f0 != 1) begin
            errors++;
            $display("FAIL pre_long got %0d required 1", ferr1_cnt - f0);
        end
        checks++;
        if (hdr_cnt - h0 != 1 || q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL pre_recover got %0d hdrs required 1", hdr_cnt - h0);
        end
    endtask

    task automatic test_hdr_abort;
        mac_hdr_t     h;
        logic [111:0] hv;
        int f0, h0, k;
        h  = '{dst: MAC, src: SRC, ethertype: 16'h0800};
        hv = h;
        f0 = ferr1_cnt; h0 = hdr_cnt;
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive(hv[111-8*i -: 8], 1'b0);
        gap(1);
        k = cyc;
        gap(3);
        checks++;
        if (ferr1_cnt - f0 != 1 || ferr1_cyc != k + 1 || hdr_cnt != h0) begin
            errors++;
            $display("FAIL hdr_abort got ferr %0d @%0d hdr %0d required 1 @%0d 0",
                     ferr1_cnt - f0, ferr1_cyc, hdr_cnt - h0, k + 1);
        end
        send_frame(7, MAC, 16'h0800, 20, 5, 8'h77);
        gap(4);
        checks++;
        if (q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL pld_err_drain got %0d pending required 0",
                     q1.size() + q2.size() + hq.size());
        end
    endtask

    task automatic test_boundaries;
        int f0, f20;
        send_frame(7, MAC, 16'h0001, 1, -1, 8'h81);
        send_frame(7, MAC, 16'h0002, 8, -1, 8'h82);
        send_frame(7, MAC, 16'h0003, 9, -1, 8'h83);
        send_frame(7, MAC, 16'h0004, 12, -1, 8'h84);
        f0 = ferr1_cnt; f20 = ferr2_cnt;
        send_frame(7, MAC, 16'h0005, 0, -1, 8'h85);
        gap(4);
        checks++;
        if (ferr1_cnt - f0 != 1 || ferr2_cnt - f20 != 1) begin
            errors++;
            $display("FAIL zero_pld got %0d/%0d required 1/1",
                     ferr1_cnt - f0, ferr2_cnt - f20);
        end
        checks++;
        if (q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL bound_drain got %0d pending required 0",
                     q1.size() + q2.size() + hq.size());
        end
    endtask

    task automatic test_back_to_back;
        int h0;
        h0 = hdr_cnt;
        for (int n = 0; n < 3; n++)
            send_frame(7 - n, (n == 1) ? BCAST_ADDR : MAC, 16'h0800,
                       3 + n * 5, (n == 2) ? 4 : -1, 8'(n * 16));
        gap(4);
        checks++;
        if (hdr_cnt - h0 != 3 || q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL b2b got %0d hdrs %0d pending required 3 0",
                     hdr_cnt - h0, q1.size() + q2.size() + hq.size());
        end
    endtask

    task automatic test_reset_mid;
        mac_hdr_t     h;
        logic [111:0] hv;
        int p0, f0;
        h  = '{dst: MAC, src: SRC, ethertype: 16'h0800};
        hv = h;
        mon_en = 1'b0;
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 14; i++) drive(hv[111-8*i -: 8], 1'b0);
        for (int i = 0; i < 6; i++) drive(8'(8'hC0 + i), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_dat = 8'hA0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_dat = 8'hA1;
        @(negedge clk);
        checks++;
        if ({pld1.val, pld2.val, hdr_val1, ferr1, dst1, src1, et1} !== 116'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got val%b%b hdr%b dst%h required 0",
                     pld1.val, pld2.val, hdr_val1, dst1);
        end
        q1.delete(); q2.delete(); hq.delete();
        mon_en = 1'b1;
        p0 = pop1; f0 = ferr1_cnt;
        for (int i = 0; i < 6; i++) drive(8'(8'h55 + i), 1'b0);
        gap(1);
        checks++;
        if (pop1 != p0 || ferr1_cnt != f0) begin
            errors++;
            $display("FAIL rst_mid_ignore got %0d bytes %0d ferr required 0 0",
                     pop1 - p0, ferr1_cnt - f0);
        end
        send_frame(7, MAC, 16'h0800, 10, -1, 8'h90);
        gap(4);
        checks++;
        if (pop1 - p0 != 10 || q1.size() + q2.size() + hq.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_resume got %0d bytes required 10", pop1 - p0);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_bcast_miss();
        test_bad_preamble();
        test_hdr_abort();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

endmodule
